// File: rtl/bshift_pkg.sv
// Shared types and helpers for the round-robin shifter front end: request
// payload struct, index-width helper and reference rotate functions.
package bshift_pkg;

    localparam int PKG_DATA_W = 32;
    localparam int PKG_DIST_W = $clog2(PKG_DATA_W);

    typedef struct packed {
        logic                  l_nr;
        logic [PKG_DIST_W-1:0] dst;
        logic [PKG_DATA_W-1:0] data;
    } req_t;

    // A single requester still needs a one-bit index.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [PKG_DATA_W-1:0] rotl(input logic [PKG_DATA_W-1:0] d, input int s);
        int k;
        k = s % PKG_DATA_W;
        return (d << k) | (d >> (PKG_DATA_W - k));
    endfunction

    function automatic logic [PKG_DATA_W-1:0] rotr(input logic [PKG_DATA_W-1:0] d, input int s);
        int k;
        k = s % PKG_DATA_W;
        return (d >> k) | (d << (PKG_DATA_W - k));
    endfunction

endpackage

// File: rtl/barrel_shifter.sv
// Registered cyclic rotator; the output word holds whenever ena is low.
module barrel_shifter #(
    parameter int DATA_W = 32,
    parameter int DIST_W = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              ena,
    input  logic              l_nr,
    input  logic [DIST_W-1:0] dst,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] res
);

    logic [DIST_W-1:0] amt;
    logic [DATA_W-1:0] rot;

    // A left rotate by d is a right rotate by (-d mod DATA_W).
    assign amt = l_nr ? (DIST_W'(0) - dst) : dst;

    always_comb begin
        rot = (data >> amt) | (data << (DATA_W - int'(amt)));
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            res <= '0;
        end else if (ena) begin
            res <= rot;
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the slot after the last
// winner; the pointer moves only when the grant is taken (adv high).
module rr_arbiter
    import bshift_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = id_width(N)
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic [N-1:0]  valid,
    input  logic          adv,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_id
);

    logic [IW-1:0] last;

    always_comb begin
        int   idx;
        logic found;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!found && valid[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            last <= IW'(N - 1);
        end else if (adv && |valid) begin
            last <= grant_id;
        end
    end

endmodule

// File: rtl/bshift_arbiter.sv
// Shares one barrel_shifter among REQ_N requesters: round-robin issue, one
// result register with backpressure, result tagged with the owner index.
module bshift_arbiter
    import bshift_pkg::*;
#(
    parameter int REQ_N  = 4,
    parameter int DATA_W = 32,
    parameter int DIST_W = $clog2(DATA_W),
    parameter int ID_W   = id_width(REQ_N)
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic [REQ_N-1:0]              req_valid,
    output logic [REQ_N-1:0]              req_ready,
    input  logic [REQ_N-1:0]              req_l_nr,
    input  logic [REQ_N-1:0][DIST_W-1:0]  req_dst,
    input  logic [REQ_N-1:0][DATA_W-1:0]  req_data,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [ID_W-1:0]               res_id,
    output logic [DATA_W-1:0]             res_data
);

    logic              adv;
    logic              hs;
    logic [REQ_N-1:0]  grant;
    logic [ID_W-1:0]   grant_id;
    logic              sel_l_nr;
    logic [DIST_W-1:0] sel_dst;
    logic [DATA_W-1:0] sel_data;

    // Gating with nrst keeps req_ready low through the whole reset cycle.
    assign adv       = (~res_valid | res_ready) & nrst;
    assign req_ready = grant & {REQ_N{adv}};
    assign hs        = |req_ready;

    rr_arbiter #(
        .N  (REQ_N),
        .IW (ID_W)
    ) u_arb (
        .clk      (clk),
        .nrst     (nrst),
        .valid    (req_valid),
        .adv      (adv),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign sel_l_nr = req_l_nr[grant_id];
    assign sel_dst  = req_dst[grant_id];
    assign sel_data = req_data[grant_id];

    barrel_shifter #(
        .DATA_W (DATA_W),
        .DIST_W (DIST_W)
    ) u_shf (
        .clk  (clk),
        .nrst (nrst),
        .ena  (hs),
        .l_nr (sel_l_nr),
        .dst  (sel_dst),
        .data (sel_data),
        .res  (res_data)
    );

    always_ff @(posedge clk) begin
        if (!nrst) begin
            res_valid <= 1'b0;
            res_id    <= '0;
        end else if (hs) begin
            res_valid <= 1'b1;
            res_id    <= grant_id;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bshift_arbiter.sv
// Directed and randomised checks of the shared shifter arbiter against
// hand-computed vectors and the bshift_pkg rotate model.
module tb_bshift_arbiter;
    import bshift_pkg::*;

    logic            clk = 1'b0;
    logic            nrst;
    logic [3:0]      req_valid;
    logic [3:0]      req_ready;
    logic [3:0]      req_l_nr;
    logic [3:0][4:0] req_dst;
    logic [3:0][31:0] req_data;
    logic            res_valid;
    logic            res_ready;
    logic [1:0]      res_id;
    logic [31:0]     res_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_rr [4] = '{32'h0000_0F00, 32'h7812_3456, 32'h0000_0018, 32'hA5A5_A5A5};

    req_t        pay [4];
    logic        mdl_valid;
    logic [1:0]  mdl_id;
    logic [31:0] mdl_data;
    int          last_m;
    int          n_acc;
    int          n_con;

    always #5 clk = ~clk;

    bshift_arbiter #(
        .REQ_N  (4),
        .DATA_W (32)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_l_nr  (req_l_nr),
        .req_dst   (req_dst),
        .req_data  (req_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_data  (res_data)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] rr_model(input logic [3:0] v, input int lst);
        logic [3:0] g;
        int idx;
        g = '0;
        for (int k = 1; k <= 4; k++) begin
            idx = (lst + k) % 4;
            if (v[idx]) begin
                g[idx] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    initial begin
        nrst      = 1'b0;
        res_ready = 1'b1;
        req_valid = 4'b1111;
        req_l_nr  = 4'b1101;
        req_dst   = '{5'd0, 5'd4, 5'd8, 5'd4};
        req_data  = '{32'hA5A5_A5A5, 32'h8000_0001, 32'h1234_5678, 32'h0000_00F0};

        // Reset held two cycles with every requester valid
        tick();
        tick();
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_id", res_id, 0);
        check("rst_req_ready", req_ready, 0);
        nrst = 1'b1;
        #1;

        // Round robin, all valid, consumer always ready
        for (int k = 0; k < 8; k++) begin
            check($sformatf("rr_ready_%0d", k), req_ready, 64'(4'b0001 << (k % 4)));
            tick();
            check($sformatf("rr_valid_%0d", k), res_valid, 1);
            check($sformatf("rr_id_%0d", k), res_id, k % 4);
            check($sformatf("rr_data_%0d", k), res_data, exp_rr[k % 4]);
        end

        // Single requester, left then right rotate
        req_valid = 4'b0100;
        #1;
        check("single_ready", req_ready, 4'b0100);
        tick();
        check("rotl_id", res_id, 2);
        check("rotl_data", res_data, 32'h0000_0018);
        req_l_nr[2] = 1'b0;
        #1;
        check("single_ready2", req_ready, 4'b0100);
        tick();
        check("rotr_data", res_data, 32'h1800_0000);
        req_valid = 4'b0000;
        tick();
        check("idle_valid", res_valid, 0);
        check("idle_data_hold", res_data, 32'h1800_0000);

        // Backpressure
        res_ready = 1'b0;
        req_valid = 4'b0010;
        #1;
        check("bp_first_ready", req_ready, 4'b0010);
        tick();
        check("bp_valid", res_valid, 1);
        check("bp_id", res_id, 1);
        check("bp_data", res_data, 32'h7812_3456);
        req_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp_stall_ready_%0d", k), req_ready, 0);
            tick();
            check($sformatf("bp_stall_valid_%0d", k), res_valid, 1);
            check($sformatf("bp_stall_id_%0d", k), res_id, 1);
            check($sformatf("bp_stall_data_%0d", k), res_data, 32'h7812_3456);
        end
        res_ready = 1'b1;
        #1;
        check("bp_release_ready", req_ready, 4'b0100);
        tick();
        check("bp_release_id", res_id, 2);
        check("bp_release_data", res_data, 32'h1800_0000);

        // Reset while a result is pending
        res_ready = 1'b0;
        #1;
        check("pend_ready", req_ready, 0);
        nrst = 1'b0;
        tick();
        check("pend_rst_valid", res_valid, 0);
        check("pend_rst_data", res_data, 0);
        check("pend_rst_id", res_id, 0);
        nrst      = 1'b1;
        res_ready = 1'b1;
        #1;
        check("pend_restart_ready", req_ready, 4'b0001);
        tick();
        check("pend_restart_id", res_id, 0);
        check("pend_restart_data", res_data, 32'h0000_0F00);

        // Random soak against the package model
        nrst      = 1'b0;
        req_valid = 4'b0000;
        tick();
        nrst      = 1'b1;
        mdl_valid = 1'b0;
        mdl_id    = '0;
        mdl_data  = '0;
        last_m    = 3;
        n_acc     = 0;
        n_con     = 0;
        for (int c = 0; c < 300; c++) begin
            logic [3:0] g_m;
            int         idx;
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] && ($urandom_range(0, 1) == 1)) begin
                    case ($urandom_range(0, 3))
                        0:       pay[i].dst = 5'd0;
                        1:       pay[i].dst = 5'd31;
                        default: pay[i].dst = 5'($urandom_range(0, 31));
                    endcase
                    pay[i].l_nr  = 1'($urandom_range(0, 1));
                    pay[i].data  = $urandom;
                    req_valid[i] = 1'b1;
                end
                req_l_nr[i] = pay[i].l_nr;
                req_dst[i]  = pay[i].dst;
                req_data[i] = pay[i].data;
            end
            res_ready = ($urandom_range(0, 3) != 0);
            #1;
            g_m = (!mdl_valid || res_ready) ? rr_model(req_valid, last_m) : 4'b0000;
            check("soak_ready", req_ready, g_m);
            check("soak_res_valid", res_valid, mdl_valid);
            if (mdl_valid) begin
                check("soak_res_id", res_id, mdl_id);
                check("soak_res_data", res_data, mdl_data);
            end
            if (res_valid && res_ready) n_con++;
            if (|(req_valid & req_ready)) n_acc++;
            idx = 0;
            if (g_m != 4'b0000) begin
                for (int i = 0; i < 4; i++) if (g_m[i]) idx = i;
                mdl_valid = 1'b1;
                mdl_id    = 2'(idx);
                mdl_data  = pay[idx].l_nr ? rotl(pay[idx].data, int'(pay[idx].dst))
                                          : rotr(pay[idx].data, int'(pay[idx].dst));
                last_m    = idx;
            end else if (res_ready) begin
                mdl_valid = 1'b0;
            end
            tick();
            if (g_m != 4'b0000) req_valid[idx] = 1'b0;
        end

        // Drain the last result and compare acceptances with deliveries
        req_valid = 4'b0000;
        res_ready = 1'b1;
        #1;
        check("drain_valid", res_valid, mdl_valid);
        if (res_valid && res_ready) n_con++;
        tick();
        check("drain_empty", res_valid, 0);
        check("soak_acc_vs_con", n_con, n_acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/bshift_arbiter.md
# bshift_arbiter

Shares one rotating `barrel_shifter` instance between `REQ_N` independent requesters. Each requester has its own valid/ready request channel. A round-robin arbiter picks one request per cycle and issues it to the shifter. The rotated word comes back on a single result channel, tagged with the requester index, and supports backpressure. The block sits between the datapath clients and the shared shifter, so the shifter is fully utilised at up to one operation per cycle.

## Interface
- `REQ_N`, 4: number of requesters, ≥2
- `DATA_W`, 32: data width, power of two, ≥2
- `DIST_W`, `$clog2(DATA_W)`: shift distance width
- `ID_W`, `$clog2(REQ_N)`: requester index width

Ports:
- `clk`  in  1  clock
- `nrst`  in  1  reset, synchronous, active-low
- `req_valid`  in  `[REQ_N]`  request present per requester
- `req_ready`  out  `[REQ_N]`  one-hot request accepted this cycle
- `req_l_nr`  in  `[REQ_N]`  1 = rotate left, 0 = rotate right
- `req_dst`  in  `[REQ_N][DIST_W]`  rotate distance
- `req_data`  in  `[REQ_N][DATA_W]`  operand
- `res_valid`  out  1  result present
- `res_ready`  in  1  result consumer ready
- `res_id`  out  `ID_W`  index of the requester that owns the result
- `res_data`  out  `DATA_W`  rotated word

## Operation
- **Slot-free condition:** `adv = ~res_valid | res_ready`.
- **Grant:** the grant vector is round-robin over `req_valid`, starting at `(last + 1) mod REQ_N`. The pointer `last` resets to `REQ_N-1`, so requester 0 has first priority.
- **Ready:** `req_ready[i] = grant[i] & adv`. It is at most one-hot and depends combinationally on `req_valid`. A handshake occurs on `req_valid[i] & req_ready[i]`.
- **Pointer update:** on a handshake, `last` takes the granted index. With no handshake, `last` holds.
- **Issue:** on a handshake, the shifter is given `ena=1` and the muxed `l_nr`, `dst` and `data`. Otherwise `ena=0`, so the shifter output holds.
- **Shift function:** a cyclic rotate. Left: `res_data = rotl(data, dst)`. Right: `res_data = rotr(data, dst)`. When `dst = 0` the data passes unchanged.
- **Result register update:** `res_valid` is set to 1 on a handshake. It is set to 0 when `res_ready` is high and there is no handshake. `res_id` loads the granted index on a handshake.
- **Stalled result:** while `res_valid & ~res_ready`, all `req_ready` are 0, and `res_data` and `res_id` stay stable.
- **Requester obligations:** a requester keeps `req_valid` high and its payload stable until it is accepted. The block never drops or reorders an accepted request.

## Timing
- **Reset values:** `res_valid=0`, `res_id=0`, `res_data=0`, `req_ready=0` (the last follows from reset gating), `last=REQ_N-1`.
- **Latency:** a request accepted at clock edge t produces `res_valid=1` with its data in the cycle after edge t.
- **Throughput:** one result per cycle while `res_ready=1`. A result is consumed and a new one accepted on the same edge.
- **Backpressure:** the slot frees in the same cycle `res_ready` rises. That cycle's handshake overwrites the result, with no bubble.
- **Reset mid-operation:** any pending result is discarded and the pointer reinitialises. `req_ready` is 0 for the whole reset cycle.
- **Fairness:** with all requesters continuously valid and `res_ready=1`, grants cycle 0,1,…,REQ_N-1. Each requester waits at most `REQ_N-1` accepted operations.

## Structure
- Package `bshift_pkg` holds the `req_t` struct {`l_nr`, `dst`, `data`}, a localparam helper for the `ID_W` calculation, and the `rotl`/`rotr` reference functions the bench uses.
- Sub-module `rr_arbiter #(N)` takes `valid[N]` and `adv`, and returns a one-hot `grant[N]`, the binary `grant_id`, and an internal pointer update. It is reusable elsewhere.
- The existing `barrel_shifter` is instantiated once, with `nrst` shared.
- The top level contains the operand mux and the `res_valid`/`res_id` registers.

## Test plan
- **Reset:** drive `nrst=0` for 2 cycles, with all requesters valid. Expect `res_valid=0`, `res_data=0`, `req_ready=0`. After release, the first grant goes to requester 0.
- **Single left rotate:** requester 2 sends `data=0x8000_0001`, `dst=4`, `l_nr=1`, with `res_ready=1`. Expect `res_id=2` and `res_data=0x0000_0018` exactly one cycle later. A right rotate by 4 gives `0x1800_0000`.
- **Round-robin:** all 4 requesters valid for 8 cycles with `res_ready=1`. Grant order is 0,1,2,3,0,1,2,3, and a result is produced every cycle.
- **Backpressure:** hold `res_ready=0` for 3 cycles while a result is valid. Expect `req_ready` to stay 0 and `res_data`/`res_id` to be unchanged. Raise `res_ready` and expect the next request to be accepted in the same cycle.
- **Reset with result pending:** assert `nrst=0` while `res_valid=1` and `res_ready=0`. On the next cycle expect `res_valid=0` and the pointer restarted, so requester 0 is granted first.
- **Random soak:** random valid, payloads, `dst` including 0 and `DATA_W-1`, and `res_ready`, compared against the `bshift_pkg` model. No loss, no duplication, and per-requester order is preserved.
